// File: rtl/rv32i_types.sv
// Shared types for the core-swap sequencer.
//   swap_state_t   : sequencer FSM state encoding
//   ARCH_IDX_W     : width of an architectural register index
//   FIRST_COPY_IDX : first register copied (x0 is hard-wired and skipped)
package rv32i_types;

    localparam int ARCH_IDX_W = 5;
    localparam logic [ARCH_IDX_W-1:0] FIRST_COPY_IDX = 5'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STALL,
        S_DRAIN,
        S_COPY,
        S_PC,
        S_DONE,
        S_ABORT
    } swap_state_t;

endpackage

// File: rtl/swap_drain_monitor.sv
// Drain monitor for the core-swap sequencer.
// Counts consecutive cycles with both back ends empty and total cycles spent
// draining, and flags when copying may start or the drain has timed out.
// Ports:
//   clk, rst                        : clock, asynchronous active-low reset
//   in_drain                        : sequencer is in its DRAIN state
//   ooo_rob_empty, ppl_pipe_empty   : back-end empty indications
//   drain_ok                        : this cycle completes the stable window
//   drain_timeout                   : this cycle is the last allowed DRAIN cycle
module swap_drain_monitor #(
    parameter int DRAIN_STABLE  = 2,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic in_drain,
    input  logic ooo_rob_empty,
    input  logic ppl_pipe_empty,
    output logic drain_ok,
    output logic drain_timeout
);

    localparam int STABLE_W  = (DRAIN_STABLE  > 1) ? $clog2(DRAIN_STABLE)  : 1;
    localparam int TIMEOUT_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [STABLE_W-1:0]  STABLE_LAST  = STABLE_W'(DRAIN_STABLE - 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(DRAIN_TIMEOUT - 1);

    logic [STABLE_W-1:0]  stable_cnt_q, stable_cnt_d;
    logic [TIMEOUT_W-1:0] timeout_cnt_q, timeout_cnt_d;
    logic                 both_empty;

    assign both_empty    = ooo_rob_empty & ppl_pipe_empty;
    assign drain_ok      = in_drain & both_empty & (stable_cnt_q == STABLE_LAST);
    assign drain_timeout = in_drain & (timeout_cnt_q == TIMEOUT_LAST);

    // Counters only run while draining; leaving DRAIN (either way) clears
    // them so the next swap starts from a clean window.
    always_comb begin
        stable_cnt_d  = '0;
        timeout_cnt_d = '0;
        if (in_drain && !drain_ok && !drain_timeout) begin
            timeout_cnt_d = timeout_cnt_q + TIMEOUT_W'(1);
            if (both_empty) begin
                stable_cnt_d = stable_cnt_q + STABLE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable_cnt_q  <= '0;
            timeout_cnt_q <= '0;
        end else begin
            stable_cnt_q  <= stable_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

endmodule

// File: rtl/core_swap_sequencer.sv
// Core-swap sequencer: migrates a thread between the out-of-order core and
// the in-order pipelined core. Stalls both front ends, waits for both back
// ends to drain, cross-copies x1..x31, cross-loads the committed PCs, then
// releases the stalls and pulses swap_done (or swap_abort on drain timeout).
// Ports:
//   clk, rst                          : clock, asynchronous active-low reset
//   swap_req                          : scheduler request, sampled in IDLE
//   ooo_rob_empty, ppl_pipe_empty     : back-end empty indications
//   ooo_commit_pc, ppl_commit_pc      : next PC to commit on each core
//   ooo_fetch_stall, ppl_fetch_stall  : front-end stalls
//   rf_rd_idx, ooo/ppl_rf_rdata       : shared read index, data next cycle
//   rf_we, rf_wr_idx, ooo/ppl_rf_wdata: crossed write port to both regfiles
//   pc_load, ooo/ppl_pc_load_val      : one-cycle swapped PC load
//   busy, swap_done, swap_abort       : status and completion pulses
//   swap_count                        : completed swaps (wrapping)
module core_swap_sequencer
    import rv32i_types::*;
#(
    parameter int DRAIN_STABLE  = 2,
    parameter int DRAIN_TIMEOUT = 1024,
    parameter int NUM_ARCH_REGS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  swap_req,
    input  logic                  ooo_rob_empty,
    input  logic                  ppl_pipe_empty,
    input  logic [31:0]           ooo_commit_pc,
    input  logic [31:0]           ppl_commit_pc,
    output logic                  ooo_fetch_stall,
    output logic                  ppl_fetch_stall,
    output logic [ARCH_IDX_W-1:0] rf_rd_idx,
    input  logic [31:0]           ooo_rf_rdata,
    input  logic [31:0]           ppl_rf_rdata,
    output logic                  rf_we,
    output logic [ARCH_IDX_W-1:0] rf_wr_idx,
    output logic [31:0]           ooo_rf_wdata,
    output logic [31:0]           ppl_rf_wdata,
    output logic                  pc_load,
    output logic [31:0]           ooo_pc_load_val,
    output logic [31:0]           ppl_pc_load_val,
    output logic                  busy,
    output logic                  swap_done,
    output logic                  swap_abort,
    output logic [15:0]           swap_count
);

    localparam logic [ARCH_IDX_W-1:0] LAST_COPY_IDX = ARCH_IDX_W'(NUM_ARCH_REGS - 1);

    swap_state_t           state_q, state_d;
    logic [ARCH_IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic                  we_q, we_d;
    logic [ARCH_IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [31:0]           ooo_wdata_q, ooo_wdata_d;
    logic [31:0]           ppl_wdata_q, ppl_wdata_d;
    logic [31:0]           ooo_pc_cap_q, ooo_pc_cap_d;
    logic [31:0]           ppl_pc_cap_q, ppl_pc_cap_d;
    logic [15:0]           count_q, count_d;
    logic                  in_drain;
    logic                  drain_ok;
    logic                  drain_timeout;

    assign in_drain = (state_q == S_DRAIN);

    swap_drain_monitor #(
        .DRAIN_STABLE  (DRAIN_STABLE),
        .DRAIN_TIMEOUT (DRAIN_TIMEOUT)
    ) u_drain_monitor (
        .clk            (clk),
        .rst            (rst),
        .in_drain       (in_drain),
        .ooo_rob_empty  (ooo_rob_empty),
        .ppl_pipe_empty (ppl_pipe_empty),
        .drain_ok       (drain_ok),
        .drain_timeout  (drain_timeout)
    );

    // Next-state logic. A drain that completes on its final allowed cycle
    // still proceeds to COPY.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (swap_req) state_d = S_STALL;
            S_STALL: state_d = S_DRAIN;
            S_DRAIN: begin
                if (drain_ok)           state_d = S_COPY;
                else if (drain_timeout) state_d = S_ABORT;
            end
            S_COPY:  if (rd_idx_q == LAST_COPY_IDX) state_d = S_PC;
            S_PC:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Copy pipeline: the read index is launched from a flop, the regfiles
    // return data by the next edge, and the write stage registers index and
    // crossed data so the write lands one cycle after its read.
    always_comb begin
        rd_idx_d     = '0;
        we_d         = (state_q == S_COPY);
        wr_idx_d     = (state_q == S_COPY) ? rd_idx_q : '0;
        ooo_wdata_d  = ooo_wdata_q;
        ppl_wdata_d  = ppl_wdata_q;
        ooo_pc_cap_d = ooo_pc_cap_q;
        ppl_pc_cap_d = ppl_pc_cap_q;
        count_d      = count_q;

        if (in_drain && drain_ok) begin
            rd_idx_d     = FIRST_COPY_IDX;
            ooo_pc_cap_d = ooo_commit_pc;
            ppl_pc_cap_d = ppl_commit_pc;
        end else if (state_q == S_COPY && rd_idx_q != LAST_COPY_IDX) begin
            rd_idx_d = rd_idx_q + ARCH_IDX_W'(1);
        end

        if (state_q == S_COPY) begin
            ooo_wdata_d = ppl_rf_rdata;
            ppl_wdata_d = ooo_rf_rdata;
        end

        if (state_q == S_DONE) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            rd_idx_q     <= '0;
            we_q         <= 1'b0;
            wr_idx_q     <= '0;
            ooo_wdata_q  <= '0;
            ppl_wdata_q  <= '0;
            ooo_pc_cap_q <= '0;
            ppl_pc_cap_q <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            rd_idx_q     <= rd_idx_d;
            we_q         <= we_d;
            wr_idx_q     <= wr_idx_d;
            ooo_wdata_q  <= ooo_wdata_d;
            ppl_wdata_q  <= ppl_wdata_d;
            ooo_pc_cap_q <= ooo_pc_cap_d;
            ppl_pc_cap_q <= ppl_pc_cap_d;
            count_q      <= count_d;
        end
    end

    // Outputs decode registered state only.
    assign busy            = (state_q != S_IDLE);
    assign ooo_fetch_stall = (state_q == S_STALL) || (state_q == S_DRAIN) ||
                             (state_q == S_COPY)  || (state_q == S_PC);
    assign ppl_fetch_stall = ooo_fetch_stall;
    assign rf_rd_idx       = rd_idx_q;
    assign rf_we           = we_q;
    assign rf_wr_idx       = wr_idx_q;
    assign ooo_rf_wdata    = ooo_wdata_q;
    assign ppl_rf_wdata    = ppl_wdata_q;
    assign pc_load         = (state_q == S_PC);
    assign ooo_pc_load_val = ppl_pc_cap_q;
    assign ppl_pc_load_val = ooo_pc_cap_q;
    assign swap_done       = (state_q == S_DONE);
    assign swap_abort      = (state_q == S_ABORT);
    assign swap_count      = count_q;

endmodule
